// File: rtl/ro_freq_meter.sv
// ro_freq_meter: ring-oscillator frequency meter; enables one channel, syncs its divided output, counts rising edges over a gate window
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start_i             measurement request (sampled in IDLE only)
//   ch_sel_i            channel to measure, latched on accepted start
//   gate_cycles_i       gate window length in clk cycles, latched on accepted start
//   osc_in_i            divided oscillator outputs, asynchronous to clk
//   ro_en_o             oscillator enables, one-hot or zero
//   busy_o, done_o      activity flag, one-cycle completion pulse
//   count_o, overflow_o edge count and sticky saturation flag
module ro_freq_meter #(
    parameter int N_CH   = 4,
    parameter int GATE_W = 16,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [$clog2(N_CH)-1:0] ch_sel_i,
    input  logic [GATE_W-1:0]       gate_cycles_i,
    input  logic [N_CH-1:0]         osc_in_i,
    output logic [N_CH-1:0]         ro_en_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [CNT_W-1:0]        count_o,
    output logic                    overflow_o
);
    localparam int CH_W = $clog2(N_CH);
    localparam int ST_W = $clog2(SETTLE);
    localparam logic [ST_W-1:0] ST_INIT = ST_W'(SETTLE - 1);
    typedef enum logic [1:0] {IDLE, SETL, MEAS, DN} state_t;
    state_t            state_q;
    logic [CH_W-1:0]   ch_q;
    logic [GATE_W-1:0] gate_q;
    logic [ST_W-1:0]   set_q;
    logic              s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]  count_q;
    logic              ovf_q, busy_q, done_q;
    logic [N_CH-1:0]   ro_en_q;
    logic              sync_d, edge_d, accept_d;
    always_comb begin
        sync_d   = osc_in_i[ch_q];
        edge_d   = s2_q & ~s3_q;
        accept_d = start_i && (int'(ch_sel_i) < N_CH);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            gate_q  <= '0;
            set_q   <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ro_en_q <= '0;
        end else begin
            s1_q <= sync_d;
            s2_q <= s1_q;
            s3_q <= s2_q;
            case (state_q)
                IDLE: if (accept_d) begin
                    count_q <= '0;
                    ovf_q   <= 1'b0;
                    busy_q  <= 1'b1;
                    if (gate_cycles_i != '0) begin
                        ch_q    <= ch_sel_i;
                        gate_q  <= gate_cycles_i;
                        set_q   <= ST_INIT;
                        ro_en_q <= {{(N_CH-1){1'b0}}, 1'b1} << ch_sel_i;
                        state_q <= SETL;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= DN;
                    end
                end
                // settle delay lets the freshly muxed channel fill s1..s3
                SETL: if (set_q == '0) state_q <= MEAS; else set_q <= set_q - 1'b1;
                MEAS: begin
                    if (edge_d) begin
                        if (&count_q) ovf_q <= 1'b1;
                        else count_q <= count_q + 1'b1;
                    end
                    if (gate_q == GATE_W'(1)) begin
                        ro_en_q <= '0;
                        done_q  <= 1'b1;
                        state_q <= DN;
                    end
                    gate_q <= gate_q - 1'b1;
                end
                DN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign ro_en_o    = ro_en_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;
endmodule
